serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder, the additive counterpart of the ALU's full subtractor: it adds two WIDTH-bit operands plus a carry-in one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It sits beside the ALU's combinational arithmetic as the low-area add path, driven by a start/done handshake from the ALU control.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- in_clk  input  1  clock; all state changes on rising edge
- in_rst_n  input  1  asynchronous, active-low reset
- in_start  input  1  request; sampled only when out_busy=0
- in_a  input  WIDTH  operand A, latched on accepted start
- in_b  input  WIDTH  operand B, latched on accepted start
- in_carry  input  1  carry-in, latched on accepted start
- out_busy  output  1  high while the add is in progress (state RUN)
- out_done  output  1  one-cycle pulse: result registers just updated
- out_sum  output  WIDTH  sum of last completed operation
- out_carry  output  1  carry-out of MSB of last completed operation
- out_overflow  output  1  signed overflow of last completed operation

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_start=1 → latch in_a, in_b into shift registers, carry flop ← in_carry, bit counter ← 0, go RUN. in_start=0 → stay.
- RUN: each cycle take bit i = LSB of both shift registers; sum_i = a_i ^ b_i ^ c; c_next = (a_i & b_i) | (c & (a_i ^ b_i)). Shift operand registers right by one; shift sum_i into the MSB of the internal result register; carry flop ← c_next; counter += 1.
- Carry into MSB (carry flop value when counter = WIDTH-1) is recorded for overflow.
- When counter = WIDTH-1 (last bit processed): go DONE; at the same edge load out_sum ← final result, out_carry ← c_next, out_overflow ← (carry into MSB) ^ c_next.
- DONE: out_done=1 for exactly this cycle. in_start=1 → accepted exactly as in IDLE (back-to-back ops); else → IDLE.
- in_start while RUN is ignored; in_a/in_b/in_carry changes after acceptance have no effect.
- out_sum/out_carry/out_overflow hold their values from completion until the next completion; they do not change during RUN.
- Counter is ceil(log2(WIDTH)) bits minimum; it never wraps during an operation.

## Timing
- Reset (async, any time incl. mid-RUN): state=IDLE, out_busy=0, out_done=0, out_sum=0, out_carry=0, out_overflow=0, internal shift/carry/counter cleared. Current operation is abandoned, no done pulse. Release is synchronous to next rising edge.
- Edge E0 samples in_start=1 (IDLE or DONE) → out_busy=1 after E0.
- Edges E1..EWIDTH process bits 0..WIDTH-1. After EWIDTH: out_busy=0, out_done=1, results valid.
- After E(WIDTH+1): out_done=0; if in_start=1 was sampled at E(WIDTH+1), out_busy=1 again.
- Latency start-sample to done: WIDTH edges. Throughput: one op per WIDTH+1 cycles back-to-back.
- out_busy and out_done are never high together; all outputs are registered.

## Test plan
- WIDTH=8, A=8'h3C, B=8'h05, carry 0, start at E0 → out_busy high for 8 cycles, out_done pulse after E8, out_sum=8'h41, out_carry=0, out_overflow=0.
- A=8'hFF, B=8'h01, carry 0 → out_sum=8'h00, out_carry=1, out_overflow=0; A=8'h7F, B=8'h01 → out_sum=8'h80, out_carry=0, out_overflow=1; A=8'h80, B=8'h80 → 8'h00, carry 1, overflow 1.
- Carry-in: A=8'h00, B=8'hFF, carry 1 → out_sum=8'h00, out_carry=1, out_overflow=0.
- Pulse in_start and change in_a/in_b every cycle during RUN → result equals operands latched at E0; exactly one out_done pulse.
- Hold in_start=1 continuously with A=8'h10/B=8'h20 then A=8'h01/B=8'h01 → done pulses 9 cycles apart, out_sum 8'h30 then 8'h02; out_sum stays 8'h30 during the second RUN.
- Complete A=8'h12,B=8'h34 (out_sum=8'h46), start another op, assert in_rst_n=0 after 4 cycles (between edges) → all outputs 0 immediately, state IDLE, no out_done; new op after release gives correct result.

Source files
------------

// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Groups the start/done handshake, operands and results of the bit-serial
//   adder into one bundle. The clock and reset are plain module ports and are
//   not part of this interface.
//
//   Signals:
//     in_start      request from the ALU control; taken only when the adder is not busy
//     in_a, in_b    WIDTH-bit operands, captured when a request is accepted
//     in_carry      carry-in, captured together with the operands
//     out_busy      high while bits are being processed
//     out_done      one-cycle pulse when the result registers have just been updated
//     out_sum       sum of the last completed addition
//     out_carry     carry out of the MSB of the last completed addition
//     out_overflow  signed (two's complement) overflow of the last completed addition
//
//   Modports:
//     master  the requester (ALU control or testbench)
//     slave   the adder itself
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             in_start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_carry;
  logic             out_busy;
  logic             out_done;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_overflow;

  modport master (
    output in_start,
    output in_a,
    output in_b,
    output in_carry,
    input  out_busy,
    input  out_done,
    input  out_sum,
    input  out_carry,
    input  out_overflow
  );

  modport slave (
    input  in_start,
    input  in_a,
    input  in_b,
    input  in_carry,
    output out_busy,
    output out_done,
    output out_sum,
    output out_carry,
    output out_overflow
  );

endinterface

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder. It adds two WIDTH-bit operands plus a carry-in one bit
//   per clock, LSB first, using a single full-adder cell and a carry
//   flip-flop. A request is taken from IDLE or DONE. WIDTH clock edges later
//   the result registers are loaded and out_done pulses for one cycle. The
//   add path is small in area and sits beside the ALU's combinational
//   arithmetic.
//
//   Ports:
//     in_clk    clock; all state changes on the rising edge
//     in_rst_n  asynchronous active-low reset; it abandons any operation in
//               progress and clears every register
//     bus       serial_adder_if.slave: handshake, operands and results
//
//   Parameters:
//     WIDTH     operand and result width in bits (>= 2)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           in_clk,
  input  logic           in_rst_n,
  serial_adder_if.slave  bus
);

  // The counter only has to hold 0..WIDTH-1. It stops at LAST_BIT, so it
  // never wraps during an operation.
  localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // Operand A's shift register also serves as the result register. Each
  // processed bit leaves at the LSB and its sum bit enters at the MSB. After
  // WIDTH shifts the register holds the complete sum.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry_q;
  logic [CNT_W-1:0] bit_cnt;

  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             overflow_q;

  logic             busy_d;
  logic             done_d;

  logic             bit_a;
  logic             bit_b;
  logic             sum_bit;
  logic             carry_next;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] result_next;

  // The full-adder cell works on the current LSBs and the carry flop.
  assign bit_a       = a_sh[0];
  assign bit_b       = b_sh[0];
  assign sum_bit     = bit_a ^ bit_b ^ carry_q;
  assign carry_next  = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));
  assign last_bit    = (bit_cnt == LAST_BIT);
  assign result_next = {sum_bit, a_sh[WIDTH-1:1]};

  // A request is taken in IDLE and in DONE, which allows back-to-back
  // operations. In RUN the request is ignored.
  assign accept = bus.in_start && (state != RUN);

  // State register.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.in_start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = bus.in_start ? RUN : IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode. The outputs are taken straight from the state register,
  // so busy and done come from flops and can never be high together.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state)
      RUN:     busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Serial datapath. The operands and carry-in are captured on an accepted
  // request and then shifted one bit per RUN cycle. The counter stops on the
  // last bit instead of wrapping.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry_q <= 1'b0;
      bit_cnt <= '0;
    end else if (accept) begin
      a_sh    <= bus.in_a;
      b_sh    <= bus.in_b;
      carry_q <= bus.in_carry;
      bit_cnt <= '0;
    end else if (state == RUN) begin
      a_sh    <= result_next;
      b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
      carry_q <= carry_next;
      if (!last_bit) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  // Result registers. They are loaded only on the edge that processes the
  // MSB, so they keep the previous result for the whole of RUN. At that edge
  // carry_q is the carry into the MSB. Signed overflow is that carry XOR the
  // carry out of the MSB.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if ((state == RUN) && last_bit) begin
      sum_q       <= result_next;
      carry_out_q <= carry_next;
      overflow_q  <= carry_q ^ carry_next;
    end
  end

  assign bus.out_busy     = busy_d;
  assign bus.out_done     = done_d;
  assign bus.out_sum      = sum_q;
  assign bus.out_carry    = carry_out_q;
  assign bus.out_overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Self-checking bench for serial_adder at WIDTH=8. A reference model
//   computes the expected sum, carry and signed overflow with plain integer
//   arithmetic. Directed vectors, randomized operands, operands scrambled
//   during RUN, back-to-back requests and a mid-operation reset are all
//   compared against that model.
module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] lastSum;
  logic         lastCarry;
  logic         lastOvf;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .bus      (bus)
  );

  // Free-running clock: rising edges at 5, 15, 25 ...; inputs are driven and
  // outputs sampled on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: {overflow, carry, sum} from integer addition.
  function automatic logic [W+1:0] refAdd(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
    logic [W:0] total;
    logic       ovf;
    total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf   = (a[W-1] == b[W-1]) && (total[W-1] != a[W-1]);
    return {ovf, total};
  endfunction

  // One comparison: counts it, and counts and reports it if it differs.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Drives the request-side signals of the interface.
  task automatic applyStimulus(input logic start, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin);
    bus.in_start = start;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_carry = cin;
  endtask

  // Checks that every result output and both handshake outputs are zero.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"},  32'(bus.out_busy), 0);
    checkOutput({tag, " done"},  32'(bus.out_done), 0);
    checkOutput({tag, " sum"},   32'(bus.out_sum), 0);
    checkOutput({tag, " carry"}, 32'(bus.out_carry), 0);
    checkOutput({tag, " ovf"},   32'(bus.out_overflow), 0);
  endtask

  // Runs one complete operation. With scramble set, the request line and the
  // operands take random values on every RUN cycle; the result must still
  // match the operands captured at acceptance.
  task automatic doOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input bit scramble, input string tag);
    logic [W+1:0] exp;
    int           busyCycles;
    int           n;
    exp = refAdd(a, b, cin);
    @(negedge clk);
    applyStimulus(1'b1, a, b, cin);
    @(negedge clk);
    applyStimulus(1'b0, a, b, cin);
    busyCycles = 0;
    n          = 0;
    while (!bus.out_done && n < 4 * W) begin
      if (bus.out_busy) busyCycles++;
      checkOutput({tag, " held sum"}, 32'(bus.out_sum), 32'(lastSum));
      if (scramble) begin
        applyStimulus(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                      1'($urandom_range(0, 1)));
      end
      @(negedge clk);
      n++;
    end
    applyStimulus(1'b0, a, b, cin);
    checkOutput({tag, " done"},       32'(bus.out_done), 1);
    checkOutput({tag, " busy@done"},  32'(bus.out_busy), 0);
    checkOutput({tag, " busyCycles"}, 32'(busyCycles), W);
    checkOutput({tag, " sum"},        32'(bus.out_sum), 32'(exp[W-1:0]));
    checkOutput({tag, " carry"},      32'(bus.out_carry), 32'(exp[W]));
    checkOutput({tag, " ovf"},        32'(bus.out_overflow), 32'(exp[W+1]));
    lastSum   = exp[W-1:0];
    lastCarry = exp[W];
    lastOvf   = exp[W+1];
    @(negedge clk);
    checkOutput({tag, " done pulse end"}, 32'(bus.out_done), 0);
    checkOutput({tag, " idle after"},     32'(bus.out_busy), 0);
  endtask

  logic [W-1:0] dirA [5] = '{8'h3C, 8'hFF, 8'h7F, 8'h80, 8'h00};
  logic [W-1:0] dirB [5] = '{8'h05, 8'h01, 8'h01, 8'h80, 8'hFF};
  logic         dirC [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int t;
    int d1;
    int d2;

    lastSum   = '0;
    lastCarry = 1'b0;
    lastOvf   = 1'b0;
    rst_n     = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);

    // Reset state.
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkAllZero("post-release");

    // Directed vectors, including the sign and carry boundaries.
    for (int i = 0; i < 5; i++) begin
      doOp(dirA[i], dirB[i], dirC[i], 1'b0, $sformatf("dir%0d", i));
    end

    // Request and operands change on every RUN cycle.
    doOp(8'hA5, 8'h3B, 1'b1, 1'b1, "scramble");

    // Back-to-back requests with in_start held high.
    @(negedge clk);
    applyStimulus(1'b1, 8'h10, 8'h20, 1'b0);
    t  = 0;
    d1 = -1;
    d2 = -1;
    while (d2 < 0 && t < 6 * W) begin
      @(negedge clk);
      t++;
      if (bus.out_done) begin
        if (d1 < 0) begin
          d1 = t;
          checkOutput("b2b first sum", 32'(bus.out_sum), 32'h30);
          applyStimulus(1'b1, 8'h01, 8'h01, 1'b0);
        end else begin
          d2 = t;
          checkOutput("b2b second sum", 32'(bus.out_sum), 32'h02);
          applyStimulus(1'b0, 8'h01, 8'h01, 1'b0);
        end
      end else if (bus.out_busy && d1 >= 0) begin
        checkOutput("b2b held sum", 32'(bus.out_sum), 32'h30);
      end
    end
    checkOutput("b2b first latency", 32'(d1), W + 1);
    checkOutput("b2b spacing", 32'(d2 - d1), W + 1);
    lastSum   = 8'h02;
    lastCarry = 1'b0;
    lastOvf   = 1'b0;
    @(negedge clk);
    checkOutput("b2b idle after", 32'(bus.out_busy), 0);

    // Complete an operation, then reset between edges partway through the next one.
    doOp(8'h12, 8'h34, 1'b0, 1'b0, "pre-reset");
    @(negedge clk);
    applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, bus.in_a, bus.in_b, 1'b0);
    checkOutput("mid busy", 32'(bus.out_busy), 1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async reset");
    lastSum   = '0;
    lastCarry = 1'b0;
    lastOvf   = 1'b0;
    @(negedge clk);
    checkAllZero("reset held");
    rst_n = 1'b1;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      checkOutput("no done after reset", 32'(bus.out_done), 0);
    end
    doOp(8'h5A, 8'h66, 1'b1, 1'b0, "post-reset");

    // Randomized operations.
    for (int i = 0; i < 20; i++) begin
      doOp(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), bit'(i % 4 == 3),
           $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
